// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  localparam int DROP_CNT_W = 16;

  // Pointers carry one extra wrap bit, so differences are taken modulo 2**pw.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int pw);
    return (a - b) & ((32'd1 << pw) - 32'd1);
  endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
module axis_pkt_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO; packets are released only once complete.
// Define AXIS_PKT_FIFO_ERR_DROP_EN to drop packets whose tlast beat has tuser[0]=1.
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 1,
  parameter int DATA_COUNT = DATA_WIDTH / 8,
  parameter int DEPTH      = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [DATA_COUNT-1:0]    s_axis_tkeep,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [DATA_COUNT-1:0]    m_axis_tkeep,
  output logic [USER_WIDTH-1:0]    m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic [$clog2(DEPTH):0]   pkt_cnt,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output logic [1:0]               wr_state_dbg
);

  // Handshake: a beat transfers on any edge where tvalid and tready are both 1;
  // once m_axis_tvalid is 1 the beat is held unchanged until m_axis_tready is 1.

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = 1 + USER_WIDTH + DATA_COUNT + DATA_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE     = PW'(1);

  wr_state_e     state, state_nx;
  logic [PW-1:0] wr_ptr, wr_ptr_nx, wr_commit, wr_commit_nx, rd_ptr, fetch_ptr;
  logic [PW-1:0] used, inflight_nx;
  logic          live, full, s_fire, commit, drop, err, wr_en;
  logic          ram_vld, out_vld, move, rd_en, m_fire, m_last_fire;
  logic [WW-1:0] rd_word, out_word;

`ifdef AXIS_PKT_FIFO_ERR_DROP_EN
  assign err = s_axis_tuser[0];
`else
  assign err = 1'b0;
`endif

  // rd_ptr advances only on consumer acceptance, so prefetched beats still hold RAM slots.
  assign used        = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
  assign inflight_nx = PW'(ptr_diff(32'(wr_ptr + ONE), 32'(wr_commit), PW));
  assign full        = (used == DEPTH_P);

  assign s_axis_tready = live && ((state == WR_DROP) || !full);
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign wr_en         = s_fire && (state != WR_DROP);
  assign wr_state_dbg  = state;

  always_comb begin
    state_nx     = state;
    wr_ptr_nx    = wr_ptr;
    wr_commit_nx = wr_commit;
    commit       = 1'b0;
    drop         = 1'b0;
    case (state)
      WR_IDLE, WR_PKT: begin
        if (s_fire) begin
          wr_ptr_nx = wr_ptr + ONE;
          if (s_axis_tlast) begin
            state_nx = WR_IDLE;
            if (err) begin
              wr_ptr_nx = wr_commit;
              drop      = 1'b1;
            end else begin
              wr_commit_nx = wr_ptr + ONE;
              commit       = 1'b1;
            end
          end else if (inflight_nx == DEPTH_P) begin
            wr_ptr_nx = wr_commit;
            drop      = 1'b1;
            state_nx  = WR_DROP;
          end else begin
            state_nx = WR_PKT;
          end
        end
      end
      WR_DROP: begin
        if (s_fire && s_axis_tlast) state_nx = WR_IDLE;
      end
      default: state_nx = WR_IDLE;
    endcase
  end

  axis_pkt_fifo_ram #(
    .WIDTH(WW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
    .rd_en  (rd_en),
    .rd_addr(fetch_ptr[AW-1:0]),
    .rd_data(rd_word)
  );

  // Two-stage prefetch: RAM read register, then the output register.
  assign m_axis_tvalid = out_vld;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = out_word;
  assign m_fire      = out_vld && m_axis_tready;
  assign m_last_fire = m_fire && m_axis_tlast;
  assign move        = ram_vld && (!out_vld || m_axis_tready);
  assign rd_en       = (ptr_diff(32'(wr_commit), 32'(fetch_ptr), PW) != 32'd0) &&
                       (!ram_vld || move);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WR_IDLE;
      live      <= 1'b0;
      wr_ptr    <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
      fetch_ptr <= '0;
      ram_vld   <= 1'b0;
      out_vld   <= 1'b0;
      out_word  <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nx;
      live      <= 1'b1;
      wr_ptr    <= wr_ptr_nx;
      wr_commit <= wr_commit_nx;
      if (rd_en) fetch_ptr <= fetch_ptr + ONE;
      if (m_fire) rd_ptr <= rd_ptr + ONE;
      if (rd_en) ram_vld <= 1'b1;
      else if (move) ram_vld <= 1'b0;
      if (move) begin
        out_vld  <= 1'b1;
        out_word <= rd_word;
      end else if (m_fire) begin
        out_vld <= 1'b0;
      end
      case ({commit, m_last_fire})
        2'b10:   pkt_cnt <= pkt_cnt + ONE;
        2'b01:   pkt_cnt <= pkt_cnt - ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo (DATA_WIDTH=64, DEPTH=16); honours AXIS_PKT_FIFO_ERR_DROP_EN.
module tb_axis_pkt_fifo;

  localparam int DW    = 64;
  localparam int UW    = 1;
  localparam int KW    = 8;
  localparam int DEPTH = 16;
  localparam int WW    = 1 + UW + KW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic [4:0]    pkt_cnt;
  logic [15:0]   drop_cnt;
  logic [1:0]    wr_state_dbg;

  axis_pkt_fifo #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .DATA_COUNT(KW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .wr_state_dbg(wr_state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard: expected output beats in order, plus hold-stable checking while stalled
  logic [WW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_word;
  logic [WW-1:0] m_word;
  assign m_word = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("m_hold_valid", m_axis_tvalid, 1);
        check("m_hold_data", m_word, prev_word);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL m_unexpected_beat: got %0h, expected no beat", m_word);
        end else begin
          check("m_beat", m_word, exp_q.pop_front());
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = m_word;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic u, input logic l);
    int guard;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    guard = 0;
    while (!s_axis_tready && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) check("s_accept_timeout", s_axis_tready, 1);
    tick();
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic [KW-1:0] k,
                          input logic err, input logic push);
    for (int i = 0; i < len; i++) begin
      logic last;
      logic u;
      last = (i == len - 1);
      u    = err && last;
      if (push) exp_q.push_back({last, u, k, base + DW'(i)});
      send_beat(base + DW'(i), k, u, last);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    repeat (4) tick();
    guard = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 200) begin
      tick();
      guard++;
    end
    check(name, exp_q.size(), 0);
  endtask

  typedef struct {
    int            len;
    logic [DW-1:0] base;
    logic [KW-1:0] keep;
    logic          err;
    logic          exp_deliver;
    int            exp_drop_delta;
  } vec_t;

  vec_t vecs[6];
  int   exp_drop;

  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    vecs[0] = '{1,  64'hA000, 8'hFF, 1'b0, 1'b1, 0};
    vecs[1] = '{2,  64'hB000, 8'h0F, 1'b0, 1'b1, 0};
`ifdef AXIS_PKT_FIFO_ERR_DROP_EN
    vecs[2] = '{3,  64'hC000, 8'hFF, 1'b1, 1'b0, 1};
`else
    vecs[2] = '{3,  64'hC000, 8'hFF, 1'b1, 1'b1, 0};
`endif
    vecs[3] = '{16, 64'hD000, 8'hFF, 1'b0, 1'b1, 0};
    vecs[4] = '{17, 64'hE000, 8'hFF, 1'b0, 1'b0, 1};
    vecs[5] = '{5,  64'hF000, 8'h01, 1'b0, 1'b1, 0};

    // Reset state
    repeat (3) tick();
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    tick();
    check("rst_release_ready", s_axis_tready, 1);

    // 1: 4-beat packet, latency and burst
    m_axis_tready = 1'b1;
    send_pkt(4, 64'h1000, 8'hFF, 1'b0, 1'b1);
    check("t1_valid_e0", m_axis_tvalid, 0);
    check("t1_pkt_cnt_1", pkt_cnt, 1);
    tick();
    check("t1_valid_e1", m_axis_tvalid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t1_burst_valid", m_axis_tvalid, 1);
      tick();
    end
    check("t1_valid_after", m_axis_tvalid, 0);
    check("t1_pkt_cnt_0", pkt_cnt, 0);

    // 2: oversize packet dropped, then a normal packet
    for (int i = 0; i < 20; i++) begin
      check("t2_ready", s_axis_tready, 1);
      send_beat(64'h2000 + DW'(i), 8'hFF, 1'b0, i == 19);
    end
    s_axis_tvalid = 1'b0;
    repeat (4) tick();
    check("t2_no_output", m_axis_tvalid, 0);
    check("t2_drop_cnt", drop_cnt, 1);
    check("t2_pkt_cnt", pkt_cnt, 0);
    send_pkt(3, 64'h2100, 8'hFF, 1'b0, 1'b1);
    wait_drain("t2_follow_drain");

    // 3: backpressure with consumer stalled
    m_axis_tready = 1'b0;
    send_pkt(5, 64'h3000, 8'hFF, 1'b0, 1'b1);
    send_pkt(5, 64'h3100, 8'hFF, 1'b0, 1'b1);
    send_pkt(5, 64'h3200, 8'hFF, 1'b0, 1'b1);
    check("t3_pkt_cnt_3", pkt_cnt, 3);
    check("t3_ready_before", s_axis_tready, 1);
    for (int i = 0; i < 5; i++)
      exp_q.push_back({i == 4, 1'b0, 8'hFF, 64'h3300 + DW'(i)});
    send_beat(64'h3300, 8'hFF, 1'b0, 1'b0);
    check("t3_full_ready", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    for (int i = 1; i < 5; i++) send_beat(64'h3300 + DW'(i), 8'hFF, 1'b0, i == 4);
    s_axis_tvalid = 1'b0;
    wait_drain("t3_drain");
    check("t3_no_drop", drop_cnt, 1);
    check("t3_pkt_cnt_0", pkt_cnt, 0);

    // Table: single beat, partial keep, error flag, exact-fit, oversize-by-one
    exp_drop = 1;
    for (int v = 0; v < 6; v++) begin
      send_pkt(vecs[v].len, vecs[v].base, vecs[v].keep, vecs[v].err, vecs[v].exp_deliver);
      wait_drain($sformatf("vec%0d_drain", v));
      exp_drop += vecs[v].exp_drop_delta;
      check($sformatf("vec%0d_drop_cnt", v), drop_cnt, exp_drop);
      check($sformatf("vec%0d_pkt_cnt", v), pkt_cnt, 0);
    end

    // 5: reset mid-packet with a committed packet queued
    m_axis_tready = 1'b0;
    send_pkt(2, 64'h5000, 8'hFF, 1'b0, 1'b0);
    repeat (3) tick();
    check("t5_queued", pkt_cnt, 1);
    send_beat(64'h5100, 8'hFF, 1'b0, 1'b0);
    s_axis_tdata = 64'h5101;
    rst = 1'b1;
    #1;
    check("t5_rst_s_ready", s_axis_tready, 0);
    check("t5_rst_m_valid", m_axis_tvalid, 0);
    check("t5_rst_m_data", m_axis_tdata, 0);
    check("t5_rst_m_last", m_axis_tlast, 0);
    check("t5_rst_m_keep", m_axis_tkeep, 0);
    check("t5_rst_pkt_cnt", pkt_cnt, 0);
    check("t5_rst_drop_cnt", drop_cnt, 0);
    tick();
    check("t5_rst_hold_s_ready", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    tick();
    check("t5_after_ready", s_axis_tready, 1);
    check("t5_after_pkt_cnt", pkt_cnt, 0);
    m_axis_tready = 1'b1;
    send_pkt(2, 64'h5200, 8'h3C, 1'b0, 1'b1);
    wait_drain("t5_drain");

    // 6: consumer takes A's tlast on the same edge B commits
    m_axis_tready = 1'b0;
    send_pkt(1, 64'h6000, 8'hFF, 1'b0, 1'b1);
    repeat (2) tick();
    check("t6_a_valid", m_axis_tvalid, 1);
    check("t6_a_last", m_axis_tlast, 1);
    for (int i = 0; i < 3; i++)
      exp_q.push_back({i == 2, 1'b0, 8'hFF, 64'h6100 + DW'(i)});
    send_beat(64'h6100, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h6101, 8'hFF, 1'b0, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h6102;
    s_axis_tlast  = 1'b1;
    m_axis_tready = 1'b1;
    check("t6_pkt_cnt_before", pkt_cnt, 1);
    check("t6_s_ready", s_axis_tready, 1);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("t6_pkt_cnt_same_edge", pkt_cnt, 1);
    for (int g = 0; g < 10 && !m_axis_tvalid; g++) tick();
    for (int k = 0; k < 3; k++) begin
      check("t6_b_contiguous", m_axis_tvalid, 1);
      tick();
    end
    check("t6_b_done", m_axis_tvalid, 0);
    check("t6_pkt_cnt_0", pkt_cnt, 0);

    repeat (4) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
